// File: rtl/seq_div_16by8.sv
// Restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Latency WIDTH edges (1 for div-by-zero/overflow); result held in DONE until out_ready.
module seq_div_16by8 #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 ovf,
   output logic                 dbz,
   output logic                 busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  r_q;
   logic [WIDTH-1:0]  q_q;
   logic [WIDTH-1:0]  div_q;

   logic              accept;
   logic              is_dbz;
   logic              is_ovf;
   logic              last_iter;
   logic [WIDTH:0]    r_shift;
   logic [WIDTH:0]    trial;
   logic [WIDTH-1:0]  r_nxt;
   logic [WIDTH-1:0]  q_nxt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   assign accept    = in_valid & in_ready;
   assign is_dbz    = (divisor == '0);
   assign is_ovf    = (dividend[2*WIDTH-1:WIDTH] >= divisor);
   assign last_iter = (state == CALC) && (cnt == CW'(WIDTH - 1));

   // Partial remainder stays below the divisor, so WIDTH bits hold it; the shifted
   // value needs one extra bit and the trial subtraction's MSB acts as the borrow.
   always_comb begin
      r_shift = {r_q, q_q[WIDTH-1]};
      trial   = r_shift - {1'b0, div_q};
      r_nxt   = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      q_nxt   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = (is_dbz || is_ovf) ? DONE : CALC;
         end
         CALC: begin
            if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         r_q       <= '0;
         q_q       <= '0;
         div_q     <= '0;
         quotient  <= '0;
         remainder <= '0;
         ovf       <= 1'b0;
         dbz       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_dbz) begin
                     quotient  <= '1;
                     remainder <= dividend[WIDTH-1:0];
                     dbz       <= 1'b1;
                     ovf       <= 1'b0;
                  end else if (is_ovf) begin
                     quotient  <= '1;
                     remainder <= '0;
                     ovf       <= 1'b1;
                     dbz       <= 1'b0;
                  end else begin
                     r_q   <= dividend[2*WIDTH-1:WIDTH];
                     q_q   <= dividend[WIDTH-1:0];
                     div_q <= divisor;
                     cnt   <= '0;
                     ovf   <= 1'b0;
                     dbz   <= 1'b0;
                  end
               end
            end
            CALC: begin
               r_q <= r_nxt;
               q_q <= q_nxt;
               cnt <= cnt + CW'(1);
               if (last_iter) begin
                  quotient  <= q_nxt;
                  remainder <= r_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/seq_div_16by8.md
Name: seq_div_16by8

Overview:
- Sequential restoring divider: the inverse of the 8x8 approximate multipliers.
- Takes a 2*WIDTH-bit product and a WIDTH-bit divisor, and returns the WIDTH-bit quotient and remainder.
- Used in the error-analysis datapath to recover an operand from an exact or approximate product, and as a standalone divide unit.
- Handshaked input and output; one quotient bit is produced per clock.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width. The dividend is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept; high only in IDLE
- dividend  input  2*WIDTH  numerator (product)
- divisor  input  WIDTH  denominator
- out_valid  output  1  result valid; held until out_ready
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  quotient
- remainder  output  WIDTH  remainder
- ovf  output  1  quotient does not fit in WIDTH bits
- dbz  output  1  divide by zero
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE and the iteration counter clears.
  - out_valid, quotient, remainder, ovf, dbz, busy all go to 0; in_ready goes to 1.
  - Reset mid-CALC or in DONE aborts the operation. The result is discarded and never presented.
- FSM states:
  - IDLE: in_ready=1. An accept is in_valid & in_ready at a rising edge (E0). Priority order at E0:
    - divisor==0: go to DONE. quotient=all-ones, remainder=dividend[WIDTH-1:0], dbz=1, ovf=0.
    - else dividend[2W-1:W] >= divisor: go to DONE. quotient=all-ones, remainder=0, ovf=1, dbz=0.
    - else: go to CALC. Load partial remainder R (WIDTH+1 bits) = {0, dividend[2W-1:W]} and Q = dividend[W-1:0]. Clear the counter, ovf and dbz.
  - CALC: one iteration per edge.
    - Shift {R,Q} left by 1.
    - T = R_shifted - {0,divisor}.
    - If T is non-negative (MSB 0): R=T and Q[0]=1. Otherwise restore R and Q[0]=0.
    - After WIDTH iterations, go to DONE. quotient=Q, remainder=R[W-1:0].
  - DONE: out_valid=1.
    - quotient, remainder, ovf and dbz are stable while out_valid & !out_ready.
    - On out_valid & out_ready, return to IDLE and deassert out_valid. Result registers keep their last values.
- Latency (edges after E0 to out_valid high):
  - Normal division: WIDTH edges (8 for the default).
  - dbz/ovf: out_valid high immediately after E0, i.e. 1 cycle.
- Throughput: the next accept is possible on the edge after output handshake. in_ready is not asserted in the same cycle as out_valid, so there is no accept/deliver overlap.
- Input values are sampled only at E0; later changes are ignored.
- in_valid while busy is ignored and does not need to be held stable by the producer.
- Arithmetic is unsigned only.
- Invariant for normal results: dividend == quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- Reset, then dividend=2873, divisor=13 -> out_valid 8 edges after accept; quotient=221, remainder=0, ovf=0, dbz=0.
- dividend=1000, divisor=7 -> quotient=142, remainder=6. dividend=0xFE01, divisor=255 -> quotient=255, remainder=0.
- dividend=0x0A00, divisor=10 -> out_valid one edge after accept; ovf=1, quotient=0xFF, remainder=0. dividend=0x1234, divisor=0 -> dbz=1, quotient=0xFF, remainder=0x34.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0. A new in_valid during this time is ignored. out_ready=1 -> IDLE the next edge, then the next operation is accepted.
- Assert rst_n=0 asynchronously at iteration 4 of 1000/7 -> all outputs 0 immediately, in_ready=1 after release, no stale out_valid. A following 2873/13 gives 221 r0.
- Random 10k pairs with divisor != 0 and high byte < divisor -> invariant holds and latency is always 8.
